ex_muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit in the EX stage, directly downstream of the ID/EX stage register.
- Consumes the latched operands (RD1/RD2 outputs of ID/EX) and the decoded multiply/divide op. Owns the architectural HI/LO registers.
- Produces a stall that the hazard logic uses to drop the ID/EX register's WriteEnable while a dependent instruction must wait.

---
 rtl/ex_muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle integer multiply/divide unit for the EX stage.
//
// Owns the architectural HI/LO registers. A MULT/MULTU/DIV/DIVU issued with
// Start runs for WIDTH radix-2 iterations (shift-add or restoring
// shift-subtract) on magnitudes, then a fix-up cycle applies the result
// signs and writes HI/LO. Stall tells the hazard logic to hold the ID/EX
// register while a dependent instruction must wait for the unit.
//
// Optional build macro: MULDIV_FAST_MULT_EN -- MULT/MULTU use a one-cycle
// combinational multiplier and skip the iterative phase.
//
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   asynchronous active-high reset
//   Start    in   issue a multiply/divide this cycle
//   Op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA     in   multiplicand / dividend (rs)
//   SrcB     in   multiplier / divisor (rt)
//   HiLoRead in   instruction in EX is MFHI/MFLO
//   MTHI     in   write MTData to HI
//   MTLO     in   write MTData to LO
//   MTData   in   data for MTHI/MTLO
//   Cancel   in   abort the in-flight operation
//   Busy     out  operation in progress
//   Done     out  one-cycle pulse after HI/LO are written by an operation
//   Stall    out  combinational hold request to the upstream register
//   HI       out  product high word / remainder
//   LO       out  product low word / quotient
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiLoRead,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic [WIDTH-1:0] MTData,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div;
  logic                 neg_lo;
  logic                 neg_hi;

  logic                 op_signed, op_div, a_neg, b_neg, fast, start_ok;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand decode: magnitudes and sign flags for the issuing instruction
  assign op_signed = ~Op[0];
  assign op_div    = Op[1];
  assign a_neg     = op_signed & SrcA[WIDTH-1];
  assign b_neg     = op_signed & SrcB[WIDTH-1];
  assign a_mag     = a_neg ? -SrcA : SrcA;
  assign b_mag     = b_neg ? -SrcB : SrcB;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast      = ~op_div;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
  assign fast      = 1'b0;
`endif

  // Cancel in IDLE outranks a simultaneous Start
  assign start_ok = (state == IDLE) & Start & ~Cancel;

  assign Busy  = (state != IDLE);
  assign Stall = Busy & (Start | HiLoRead | MTHI | MTLO);

  // Multiply step: add multiplicand to the upper half if the multiplier LSB
  // is set, then shift the whole accumulator right (carry becomes the MSB).
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: partial remainder (upper half) shifted left with
  // the next dividend bit; keep the difference when it does not borrow.
  // Quotient bits shift into the lower half as the dividend shifts out.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up applied in FIX
  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = fast ? FIX : CALC;
      CALC: begin
        if (Cancel)                       state_next = IDLE;
        else if (cnt == CW'(WIDTH - 1))   state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        // Issue: capture magnitudes, sign flags and op
        IDLE: begin
          if (start_ok) begin
            is_div <= op_div;
            cnt    <= '0;
            neg_hi <= a_neg;
            // Divide by zero keeps the quotient all ones and remainder = SrcA
            neg_lo <= op_div ? ((a_neg ^ b_neg) & (SrcB != '0)) : (a_neg ^ b_neg);
            opnd   <= op_div ? b_mag : a_mag;
`ifdef MULDIV_FAST_MULT_EN
            acc    <= op_div ? {{WIDTH{1'b0}}, a_mag} : fast_prod;
`else
            acc    <= op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
`endif
          end else if (!Start) begin
            if (MTHI) HI <= MTData;
            if (MTLO) LO <= MTData;
          end
        end
        // Iterate: one radix-2 step per edge
        CALC: begin
          if (!Cancel) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
          end
        end
        // Fix-up: apply signs, commit HI/LO
        FIX: begin
          if (!Cancel) begin
            if (is_div) begin
              HI <= rem_fix;
              LO <= quo_fix;
            end else begin
              HI <= prod_fix[2*WIDTH-1:WIDTH];
              LO <= prod_fix[WIDTH-1:0];
            end
            Done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed bench for ex_muldiv_unit with an
// arithmetic reference model for HI/LO results and latency.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          hilo_read, mthi, mtlo, cancel;
  logic [W-1:0]  mt_data;
  logic          busy, done, stall;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int failures = 0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Op(op), .SrcA(src_a), .SrcB(src_b),
    .HiLoRead(hilo_read), .MTHI(mthi), .MTLO(mtlo), .MTData(mt_data), .Cancel(cancel),
    .Busy(busy), .Done(done), .Stall(stall), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
  localparam logic [1:0] LONG_OP = 2'b10;
`else
  localparam bit FAST = 1'b0;
  localparam logic [1:0] LONG_OP = 2'b00;
`endif

  // Reference model: plain integer arithmetic per the architectural rules
  function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa, sb;
    sa = a;
    sb = b;
    rhi = '0;
    rlo = '0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        rhi = sp[63:32]; rlo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        rhi = up[63:32]; rlo = up[31:0];
      end
      default: begin
        if (b == 0) begin
          rlo = '1; rhi = a;
        end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rlo = 32'h8000_0000; rhi = '0;
        end else if (o == 2'b10) begin
          rlo = sa / sb; rhi = sa % sb;
        end else begin
          rlo = a / b; rhi = a % b;
        end
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] o);
    return (FAST && !o[1]) ? 1 : W + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for Done; reports edges after E0 and
  // the number of sampled cycles with Busy high.
  task automatic issue_and_wait(input logic [1:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, output int edges, output int busy_cnt);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, stall} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl busy/done/stall=%b expected 000", {busy, done, stall});
    end
    checks++;
    if (hi !== '0 || lo !== '0) begin
      failures++; $display("FAIL reset_hilo hi=%h lo=%h expected 0/0", hi, lo);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]   ops [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [W-1:0] as  [6] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [W-1:0] bs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd7};
    logic [W-1:0] hs  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'd100, 32'd2};
    logic [W-1:0] ls  [6] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14};
    int edges, bc;
    for (int i = 0; i < 6; i++) begin
      issue_and_wait(ops[i], as[i], bs[i], edges, bc);
      checks++;
      if (edges !== exp_latency(ops[i])) begin
        failures++; $display("FAIL dir_latency[%0d] edges=%0d expected %0d", i, edges, exp_latency(ops[i]));
      end
      checks++;
      if (bc !== exp_latency(ops[i])) begin
        failures++; $display("FAIL dir_busy_cycles[%0d] got=%0d expected %0d", i, bc, exp_latency(ops[i]));
      end
      checks++;
      if (hi !== hs[i] || lo !== ls[i]) begin
        failures++; $display("FAIL dir_result[%0d] hi=%h lo=%h expected %h/%h", i, hi, lo, hs[i], ls[i]);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        failures++; $display("FAIL dir_done_pulse[%0d] done=%b expected 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [W-1:0] a, b, eh, el;
    int edges, bc, sel;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 9)) : 32'($urandom_range(1, 9));
      ref_model(o, a, b, eh, el);
      issue_and_wait(o, a, b, edges, bc);
      checks++;
      if (edges !== exp_latency(o)) begin
        failures++; $display("FAIL rnd_latency[%0d] op=%0d edges=%0d expected %0d", i, o, edges, exp_latency(o));
      end
      checks++;
      if (hi !== eh || lo !== el) begin
        failures++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h hi=%h lo=%h expected %h/%h",
                             i, o, a, b, hi, lo, eh, el);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] eh, el;
    int n;
    logic saw_done;
    ref_model(LONG_OP, 32'd7, 32'hFFFF_FFFD, eh, el);
    op = LONG_OP; src_a = 32'd7; src_b = 32'hFFFF_FFFD; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL stall_idle_request stall=%b expected 0", stall);
    end
    hilo_read = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL stall_hiloread stall=%b expected 1", stall);
    end
    n = 5;
    saw_done = 1'b0;
    while (n < 100) begin
      tick();
      n++;
      if (done) begin saw_done = 1'b1; break; end
      if (n >= 6 && n <= 10) begin start = 1'b1; op = 2'b11; end
      else start = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b1) begin
        failures++; $display("FAIL stall_while_busy edge=%0d stall=%b expected 1", n, stall);
      end
    end
    start = 1'b0;
    checks++;
    if (!saw_done) begin
      failures++; $display("FAIL stall_done_timeout done=%b expected 1", done);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL stall_done_cycle stall=%b expected 0", stall);
    end
    hilo_read = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || hi !== eh || lo !== el) begin
      failures++; $display("FAIL stall_second_start busy=%b hi=%h lo=%h expected 0 %h/%h", busy, hi, lo, eh, el);
    end
  endtask

  task automatic test_mt();
    logic [W-1:0] lo_prev, hi_prev, eh, el;
    int edges, bc;
    lo_prev = lo;
    mt_data = 32'h1234; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== lo_prev) begin
      failures++; $display("FAIL mthi hi=%h lo=%h expected 00001234/%h", hi, lo, lo_prev);
    end
    mt_data = 32'hCAFE_0001; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hCAFE_0001) begin
      failures++; $display("FAIL mtlo hi=%h lo=%h expected 00001234/cafe0001", hi, lo);
    end
    mt_data = 32'h5A5A_A5A5; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'h5A5A_A5A5 || lo !== 32'h5A5A_A5A5) begin
      failures++; $display("FAIL mthi_mtlo hi=%h lo=%h expected 5a5aa5a5 both", hi, lo);
    end
    // Start together with MTHI in IDLE: write dropped, op issued
    hi_prev = hi;
    op = 2'b11; src_a = 32'd50; src_b = 32'd3; start = 1'b1;
    mt_data = 32'h0BAD_0BAD; mthi = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || hi !== hi_prev) begin
      failures++; $display("FAIL start_wins_mt busy=%b hi=%h expected 1/%h", busy, hi, hi_prev);
    end
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL mt_busy_stall stall=%b expected 1", stall);
    end
    tick(); tick();
    mthi = 1'b0;
    checks++;
    if (hi !== hi_prev) begin
      failures++; $display("FAIL mt_busy_ignored hi=%h expected %h", hi, hi_prev);
    end
    ref_model(2'b11, 32'd50, 32'd3, eh, el);
    edges = 0;
    while (!done && edges < 100) begin tick(); edges++; end
    checks++;
    if (hi !== eh || lo !== el) begin
      failures++; $display("FAIL mt_then_op hi=%h lo=%h expected %h/%h", hi, lo, eh, el);
    end
    tick();
    bc = 0;
  endtask

  task automatic test_cancel();
    logic seen_done;
    mt_data = 32'h1111_2222; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    op = 2'b11; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL cancel_idle busy=%b expected 0", busy);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++; $display("FAIL cancel_no_done done_seen=%b expected 0", seen_done);
    end
    checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222) begin
      failures++; $display("FAIL cancel_hilo hi=%h lo=%h expected 11112222 both", hi, lo);
    end
    // Cancel in IDLE beats Start
    start = 1'b1; cancel = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd3;
    tick();
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL cancel_beats_start busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    op = LONG_OP; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_busy_before busy=%b expected 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++; $display("FAIL rstmid_async busy=%b hi=%h lo=%h expected 0 0/0", busy, hi, lo);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_after busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    hilo_read = 1'b0; mthi = 1'b0; mtlo = 1'b0; mt_data = '0; cancel = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_mt();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
